// File: rtl/mem_fill_arbiter.sv
// Round-robin arbiter that shares one backing-memory port between the
// I-cache (port 0, line fills) and the D-cache (port 1, fills or writes).
module mem_fill_arbiter #(
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 32
) (
    input  logic                              MEM_CLK,
    input  logic                              RST,
    input  logic                              REQ0_VALID,
    input  logic [ADDR_W-1:0]                 REQ0_ADDR,
    output logic                              REQ0_READY,
    output logic                              REQ0_DVALID,
    output logic                              REQ0_DONE,
    input  logic                              REQ1_VALID,
    input  logic                              REQ1_WE,
    input  logic [ADDR_W-1:0]                 REQ1_ADDR,
    input  logic [DATA_W-1:0]                 REQ1_WDATA,
    output logic                              REQ1_READY,
    output logic                              REQ1_DVALID,
    output logic                              REQ1_DONE,
    output logic [DATA_W-1:0]                 REQ_DATA,
    output logic [$clog2(WORDS_PER_LINE)-1:0] REQ_WIDX,
    output logic                              MM_RDEN,
    output logic                              MM_WE,
    output logic [ADDR_W-1:0]                 MM_ADDR,
    output logic [DATA_W-1:0]                 MM_DIN,
    input  logic [DATA_W-1:0]                 MM_DOUT,
    input  logic                              MM_VALID,
    output logic                              GRANT,
    output logic                              BUSY
);

    localparam int WIDX_W = $clog2(WORDS_PER_LINE);
    localparam int BASE_W = ADDR_W - WIDX_W;
    localparam logic [WIDX_W-1:0] LAST = WIDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        DONE
    } state_t;

    state_t              state;
    logic                rr;
    logic                we_q;
    logic [BASE_W-1:0]   base_q;
    logic [WIDX_W-1:0]   cnt;

    logic                both;
    logic                pick;
    logic                grant_go;
    logic                pick_we;
    logic [BASE_W-1:0]   pick_base;

    // Port 0 only ever fills, so its word-select bits carry no meaning.
    logic unused_addr_bits;
    assign unused_addr_bits = ^REQ0_ADDR[WIDX_W-1:0];

    // Pick a winner in IDLE; the pointer only matters when both ask at once.
    always_comb begin
        both      = REQ0_VALID & REQ1_VALID;
        pick      = both ? rr : REQ1_VALID;
        grant_go  = ~RST & (state == IDLE) & (REQ0_VALID | REQ1_VALID);
        pick_we   = pick & REQ1_WE;
        pick_base = pick ? REQ1_ADDR[ADDR_W-1:WIDX_W]
                         : REQ0_ADDR[ADDR_W-1:WIDX_W];
    end

    assign REQ0_READY = grant_go & ~pick;
    assign REQ1_READY = grant_go & pick;

    // Transaction sequencer: grant, issue each word, gap, then done.
    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            rr          <= 1'b0;
            we_q        <= 1'b0;
            base_q      <= '0;
            cnt         <= '0;
            GRANT       <= 1'b0;
            BUSY        <= 1'b0;
            MM_RDEN     <= 1'b0;
            MM_WE       <= 1'b0;
            MM_ADDR     <= '0;
            MM_DIN      <= '0;
            REQ_DATA    <= '0;
            REQ_WIDX    <= '0;
            REQ0_DVALID <= 1'b0;
            REQ1_DVALID <= 1'b0;
            REQ0_DONE   <= 1'b0;
            REQ1_DONE   <= 1'b0;
        end else begin
            REQ0_DVALID <= 1'b0;
            REQ1_DVALID <= 1'b0;
            REQ0_DONE   <= 1'b0;
            REQ1_DONE   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_go) begin
                        GRANT  <= pick;
                        BUSY   <= 1'b1;
                        we_q   <= pick_we;
                        base_q <= pick_base;
                        cnt    <= '0;
                        state  <= ISSUE;
                        if (pick_we) begin
                            MM_WE   <= 1'b1;
                            MM_ADDR <= REQ1_ADDR;
                            MM_DIN  <= REQ1_WDATA;
                        end else begin
                            MM_RDEN <= 1'b1;
                            MM_ADDR <= {pick_base, {WIDX_W{1'b0}}};
                        end
                    end
                end
                ISSUE: begin
                    if (MM_VALID) begin
                        MM_RDEN <= 1'b0;
                        MM_WE   <= 1'b0;
                        if (!we_q) begin
                            REQ_DATA    <= MM_DOUT;
                            REQ_WIDX    <= cnt;
                            REQ0_DVALID <= ~GRANT;
                            REQ1_DVALID <= GRANT;
                        end
                        if (!we_q && cnt != LAST) begin
                            cnt   <= cnt + 1'b1;
                            state <= GAP;
                        end else begin
                            REQ0_DONE <= ~GRANT;
                            REQ1_DONE <= GRANT;
                            state     <= DONE;
                        end
                    end
                end
                GAP: begin
                    MM_RDEN <= 1'b1;
                    MM_ADDR <= {base_q, cnt};
                    state   <= ISSUE;
                end
                DONE: begin
                    rr    <= ~GRANT;
                    cnt   <= '0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-delay memory model
// (D = 3) whose contents are a simple function of the word address.
module tb_mem_fill_arbiter;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic [13:0] req0_addr;
    logic        req0_ready, req0_dvalid, req0_done;
    logic        req1_valid, req1_we;
    logic [13:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ready, req1_dvalid, req1_done;
    logic [31:0] req_data;
    logic [2:0]  req_widx;
    logic        mm_rden, mm_we;
    logic [13:0] mm_addr;
    logic [31:0] mm_din, mm_dout;
    logic        mm_valid;
    logic        grant, busy;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    mem_fill_arbiter #(
        .WORDS_PER_LINE(8),
        .ADDR_W(14),
        .DATA_W(32)
    ) dut (
        .MEM_CLK(clk), .RST(rst),
        .REQ0_VALID(req0_valid), .REQ0_ADDR(req0_addr),
        .REQ0_READY(req0_ready), .REQ0_DVALID(req0_dvalid),
        .REQ0_DONE(req0_done),
        .REQ1_VALID(req1_valid), .REQ1_WE(req1_we),
        .REQ1_ADDR(req1_addr), .REQ1_WDATA(req1_wdata),
        .REQ1_READY(req1_ready), .REQ1_DVALID(req1_dvalid),
        .REQ1_DONE(req1_done),
        .REQ_DATA(req_data), .REQ_WIDX(req_widx),
        .MM_RDEN(mm_rden), .MM_WE(mm_we), .MM_ADDR(mm_addr),
        .MM_DIN(mm_din), .MM_DOUT(mm_dout), .MM_VALID(mm_valid),
        .GRANT(grant), .BUSY(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return {8'hA5, a[7:0], 2'b00, a};
    endfunction

    // Memory model: MM_VALID on the D-th cycle after the enable first rises.
    int   dcnt = 0;
    logic model_valid;
    logic inj_valid;
    assign model_valid = (mm_rden | mm_we) && (dcnt == D);
    assign mm_valid = model_valid | inj_valid;
    assign mm_dout = mem_word(mm_addr);
    always @(posedge clk) begin
        if ((mm_rden | mm_we) && !model_valid) dcnt <= dcnt + 1;
        else dcnt <= 0;
    end

    // Event log sampled mid-cycle.
    int          dv_port[$];
    int          dv_widx[$];
    logic [31:0] dv_data[$];
    int          dv_cyc[$];
    int          done_port[$];
    int          done_cyc[$];
    int          rdy_port[$];
    logic [13:0] acc_addr[$];
    int          rise_cyc[$];
    int          we_cycles = 0;
    logic        rden_q = 1'b0;

    always @(negedge clk) begin
        if (req0_dvalid) begin
            dv_port.push_back(0); dv_widx.push_back(int'(req_widx));
            dv_data.push_back(req_data); dv_cyc.push_back(cyc);
        end
        if (req1_dvalid) begin
            dv_port.push_back(1); dv_widx.push_back(int'(req_widx));
            dv_data.push_back(req_data); dv_cyc.push_back(cyc);
        end
        if (req0_done) begin done_port.push_back(0); done_cyc.push_back(cyc); end
        if (req1_done) begin done_port.push_back(1); done_cyc.push_back(cyc); end
        if (req0_ready) rdy_port.push_back(0);
        if (req1_ready) rdy_port.push_back(1);
        if (mm_rden && mm_valid) acc_addr.push_back(mm_addr);
        if (mm_rden && !rden_q) rise_cyc.push_back(cyc);
        if (mm_we) we_cycles <= we_cycles + 1;
        rden_q <= mm_rden;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic request(input int port, input logic we,
                           input logic [13:0] addr, input logic [31:0] wd,
                           output int rc, output bit ok);
        int i;
        ok = 0; rc = -1; i = 0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_addr = addr;
        end else begin
            req1_valid = 1'b1; req1_we = we;
            req1_addr = addr; req1_wdata = wd;
        end
        while (!ok && i < 100) begin
            @(negedge clk);
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
                ok = 1; rc = cyc;
            end
            i++;
        end
        @(posedge clk); #1;
        if (port == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic wait_done(input int port, output int dc, output bit ok);
        int i;
        ok = 0; dc = -1; i = 0;
        while (!ok && i < 300) begin
            @(negedge clk);
            if ((port == 0 && req0_done) || (port == 1 && req1_done)) begin
                ok = 1; dc = cyc;
            end
            i++;
        end
        @(posedge clk); #1;
    endtask

    task automatic both_race(input logic [13:0] a0, input logic [13:0] a1,
                             output int r0, output int r1,
                             output int dfirst, output bit ok);
        bit g0, g1;
        int i, d0, d1;
        g0 = 0; g1 = 0; i = 0;
        r0 = -1; r1 = -1; d0 = -1; d1 = -1;
        req0_valid = 1'b1; req0_addr = a0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = a1;
        while (!(g0 && g1) && i < 300) begin
            @(negedge clk);
            if (req0_ready) begin g0 = 1; r0 = cyc; end
            if (req1_ready) begin g1 = 1; r1 = cyc; end
            if (req0_done) d0 = cyc;
            if (req1_done) d1 = cyc;
            @(posedge clk); #1;
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
            i++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        ok = g0 && g1;
        dfirst = (r0 < r1) ? d0 : d1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; req1_we = 1'b1;
        #1;
        compared++;
        if ({req0_ready, req0_dvalid, req0_done, req1_ready, req1_dvalid,
             req1_done, mm_rden, mm_we, grant, busy} !== 10'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b want 0", {req0_ready, req0_dvalid,
                     req0_done, req1_ready, req1_dvalid, req1_done, mm_rden,
                     mm_we, grant, busy});
        end
        compared++;
        if ({mm_addr, mm_din, req_data, req_widx} !== 81'b0) begin
            mismatched++;
            $display("FAIL reset_data: got addr=%h din=%h data=%h widx=%0d want 0",
                     mm_addr, mm_din, req_data, req_widx);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; req1_we = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        compared++;
        if ({busy, mm_rden, req0_ready, req1_ready} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_idle: got %b want 0",
                     {busy, mm_rden, req0_ready, req1_ready});
        end
    endtask

    task automatic test_port0_fill();
        int rc, dc, b_dv, b_rise, b_done, n;
        bit ok, ok2;
        b_dv = dv_port.size(); b_rise = rise_cyc.size(); b_done = done_port.size();
        request(0, 1'b0, 14'h0040, 32'h0, rc, ok);
        wait_done(0, dc, ok2);
        compared++;
        if (!(ok && ok2)) begin
            mismatched++;
            $display("FAIL fill0_handshake: got ready=%0d done=%0d want 1 1", ok, ok2);
        end
        n = dv_port.size() - b_dv;
        compared++;
        if (n !== 8) begin
            mismatched++;
            $display("FAIL fill0_dvalid_count: got %0d want 8", n);
        end
        if (n == 8) begin
            for (int i = 0; i < 8; i++) begin
                compared++;
                if (dv_port[b_dv+i] !== 0 || dv_widx[b_dv+i] !== i ||
                    dv_data[b_dv+i] !== mem_word(14'(64 + i))) begin
                    mismatched++;
                    $display("FAIL fill0_word%0d: got port=%0d widx=%0d data=%h want 0 %0d %h",
                             i, dv_port[b_dv+i], dv_widx[b_dv+i], dv_data[b_dv+i],
                             i, mem_word(14'(64 + i)));
                end
            end
            compared++;
            if (dv_cyc[b_dv] !== rc + 2 + D) begin
                mismatched++;
                $display("FAIL fill0_first_latency: got %0d want %0d",
                         dv_cyc[b_dv] - rc, 2 + D);
            end
            for (int i = 1; i < 8; i++) begin
                compared++;
                if (dv_cyc[b_dv+i] - dv_cyc[b_dv+i-1] !== D + 2) begin
                    mismatched++;
                    $display("FAIL fill0_spacing%0d: got %0d want %0d", i,
                             dv_cyc[b_dv+i] - dv_cyc[b_dv+i-1], D + 2);
                end
            end
            compared++;
            if (dc !== dv_cyc[b_dv+7]) begin
                mismatched++;
                $display("FAIL fill0_done_with_last: got %0d want %0d", dc, dv_cyc[b_dv+7]);
            end
        end
        compared++;
        if (rise_cyc.size() - b_rise !== 8 || rise_cyc[b_rise] !== rc + 1) begin
            mismatched++;
            $display("FAIL fill0_rden: got rises=%0d first=+%0d want 8 +1",
                     rise_cyc.size() - b_rise, rise_cyc[b_rise] - rc);
        end
        for (int i = 1; i < 8 && b_rise + i < rise_cyc.size(); i++) begin
            compared++;
            if (rise_cyc[b_rise+i] - rise_cyc[b_rise+i-1] !== D + 2) begin
                mismatched++;
                $display("FAIL fill0_gap%0d: got %0d want %0d", i,
                         rise_cyc[b_rise+i] - rise_cyc[b_rise+i-1], D + 2);
            end
        end
        compared++;
        if (done_port.size() - b_done !== 1) begin
            mismatched++;
            $display("FAIL fill0_done_count: got %0d want 1", done_port.size() - b_done);
        end
    endtask

    task automatic test_arbitration();
        int r0, r1, df, dc, rc;
        bit ok, ok2;
        do_reset();
        both_race(14'h0200, 14'h0300, r0, r1, df, ok);
        wait_done(1, dc, ok2);
        compared++;
        if (!(ok && ok2)) begin
            mismatched++;
            $display("FAIL arb1_handshake: got grants=%0d done=%0d want 1 1", ok, ok2);
        end
        compared++;
        if (!(r0 >= 0 && r0 < r1)) begin
            mismatched++;
            $display("FAIL arb1_port0_first: got r0=%0d r1=%0d want r0<r1", r0, r1);
        end
        compared++;
        if (r1 !== df + 1) begin
            mismatched++;
            $display("FAIL arb1_second_after_done: got %0d want %0d", r1, df + 1);
        end
        request(0, 1'b0, 14'h0208, 32'h0, rc, ok);
        wait_done(0, dc, ok2);
        both_race(14'h0210, 14'h0310, r0, r1, df, ok);
        wait_done(0, dc, ok2);
        compared++;
        if (!(ok && ok2 && r1 >= 0 && r1 < r0)) begin
            mismatched++;
            $display("FAIL arb2_port1_first: got r0=%0d r1=%0d want r1<r0", r0, r1);
        end
        compared++;
        if (r0 !== df + 1) begin
            mismatched++;
            $display("FAIL arb2_second_after_done: got %0d want %0d", r0, df + 1);
        end
    endtask

    task automatic test_write();
        int rc, dc, b_dv, b_rise, b_we, b_done, bad, i;
        bit ok, fin;
        b_dv = dv_port.size(); b_rise = rise_cyc.size();
        b_we = we_cycles; b_done = done_port.size();
        request(1, 1'b1, 14'h0123, 32'hDEADBEEF, rc, ok);
        compared++;
        if (!ok || mm_we !== 1'b1 || mm_rden !== 1'b0 ||
            mm_addr !== 14'h0123 || mm_din !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL write_issue: got we=%b rden=%b addr=%h din=%h want 1 0 0123 deadbeef",
                     mm_we, mm_rden, mm_addr, mm_din);
        end
        bad = 0; fin = 0; i = 0; dc = -1;
        while (!fin && i < 100) begin
            @(negedge clk);
            if (mm_we && (mm_addr !== 14'h0123 || mm_din !== 32'hDEADBEEF || mm_rden))
                bad++;
            if (req1_done) begin fin = 1; dc = cyc; end
            i++;
        end
        @(posedge clk); #1;
        compared++;
        if (!fin || bad !== 0) begin
            mismatched++;
            $display("FAIL write_stable: got done=%0d bad=%0d want 1 0", fin, bad);
        end
        compared++;
        if (we_cycles - b_we !== D + 1) begin
            mismatched++;
            $display("FAIL write_we_cycles: got %0d want %0d", we_cycles - b_we, D + 1);
        end
        compared++;
        if (dc !== rc + D + 2) begin
            mismatched++;
            $display("FAIL write_done_time: got +%0d want +%0d", dc - rc, D + 2);
        end
        compared++;
        if (dv_port.size() - b_dv !== 0 || rise_cyc.size() - b_rise !== 0 ||
            done_port.size() - b_done !== 1) begin
            mismatched++;
            $display("FAIL write_no_read: got dv=%0d rden=%0d done=%0d want 0 0 1",
                     dv_port.size() - b_dv, rise_cyc.size() - b_rise,
                     done_port.size() - b_done);
        end
    endtask

    task automatic test_port1_fill();
        int rc, dc, b_dv, b_acc, b_done, b_rdy, p0;
        bit ok, ok2;
        b_dv = dv_port.size(); b_acc = acc_addr.size();
        b_done = done_port.size(); b_rdy = rdy_port.size();
        request(1, 1'b0, 14'h0045, 32'h0, rc, ok);
        wait_done(1, dc, ok2);
        compared++;
        if (!(ok && ok2) || acc_addr.size() - b_acc !== 8) begin
            mismatched++;
            $display("FAIL fill1_accesses: got ok=%0d n=%0d want 1 8",
                     ok && ok2, acc_addr.size() - b_acc);
        end
        for (int i = 0; i < 8 && b_acc + i < acc_addr.size(); i++) begin
            compared++;
            if (acc_addr[b_acc+i] !== 14'(64 + i)) begin
                mismatched++;
                $display("FAIL fill1_addr%0d: got %h want %h", i,
                         acc_addr[b_acc+i], 14'(64 + i));
            end
        end
        p0 = 0;
        for (int i = b_dv; i < dv_port.size(); i++) if (dv_port[i] != 1) p0++;
        for (int i = b_done; i < done_port.size(); i++) if (done_port[i] != 1) p0++;
        for (int i = b_rdy; i < rdy_port.size(); i++) if (rdy_port[i] != 1) p0++;
        compared++;
        if (p0 !== 0 || dv_port.size() - b_dv !== 8) begin
            mismatched++;
            $display("FAIL fill1_port_routing: got port0_events=%0d dv=%0d want 0 8",
                     p0, dv_port.size() - b_dv);
        end
        compared++;
        if (dv_port.size() - b_dv == 8 && dv_data[b_dv+5] !== mem_word(14'h0045)) begin
            mismatched++;
            $display("FAIL fill1_data5: got %h want %h", dv_data[b_dv+5], mem_word(14'h0045));
        end
    endtask

    task automatic test_reset_abort();
        int rc, n, i, ev, r0, r1, df, dc;
        bit ok, ok2, hit;
        request(1, 1'b0, 14'h0100, 32'h0, rc, ok);
        n = 0; i = 0; hit = 0;
        while (!hit && i < 200) begin
            @(negedge clk);
            if (req1_dvalid) n++;
            if (n == 3 && mm_rden) hit = 1;
            i++;
        end
        compared++;
        if (!(ok && hit) || busy !== 1'b1 || grant !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_setup: got ok=%0d hit=%0d busy=%b grant=%b want 1 1 1 1",
                     ok, hit, busy, grant);
        end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if ({req0_ready, req0_dvalid, req0_done, req1_ready, req1_dvalid,
             req1_done, mm_rden, mm_we, grant, busy} !== 10'b0) begin
            mismatched++;
            $display("FAIL abort_ctrl_zero: got %b want 0", {req0_ready, req0_dvalid,
                     req0_done, req1_ready, req1_dvalid, req1_done, mm_rden,
                     mm_we, grant, busy});
        end
        compared++;
        if ({mm_addr, mm_din, req_data, req_widx} !== 81'b0) begin
            mismatched++;
            $display("FAIL abort_data_zero: got addr=%h data=%h widx=%0d want 0",
                     mm_addr, req_data, req_widx);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        ev = 0;
        repeat (12) begin
            @(negedge clk);
            if (req1_done || req1_dvalid || req0_done || req0_dvalid || busy) ev++;
        end
        @(posedge clk); #1;
        compared++;
        if (ev !== 0) begin
            mismatched++;
            $display("FAIL abort_silent: got %0d events want 0", ev);
        end
        both_race(14'h0140, 14'h0180, r0, r1, df, ok);
        wait_done(1, dc, ok2);
        compared++;
        if (!(ok && ok2 && r0 >= 0 && r0 < r1 && r1 == df + 1)) begin
            mismatched++;
            $display("FAIL abort_pointer_reset: got r0=%0d r1=%0d done0=%0d want port0 first",
                     r0, r1, df);
        end
    endtask

    task automatic test_spurious_valid();
        logic [31:0] data_before;
        logic [2:0]  widx_before;
        int ev, rc, dc, b_dv, b_acc, i;
        bit ok, ok2, hit, gap_ok;
        data_before = req_data;
        widx_before = req_widx;
        inj_valid = 1'b1;
        @(posedge clk); #1;
        inj_valid = 1'b0;
        ev = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || req0_dvalid || req1_dvalid || mm_rden || mm_we) ev++;
        end
        @(posedge clk); #1;
        compared++;
        if (ev !== 0 || req_data !== data_before || req_widx !== widx_before) begin
            mismatched++;
            $display("FAIL idle_valid_ignored: got ev=%0d data=%h widx=%0d want 0 %h %0d",
                     ev, req_data, req_widx, data_before, widx_before);
        end
        b_dv = dv_port.size(); b_acc = acc_addr.size();
        request(0, 1'b0, 14'h0080, 32'h0, rc, ok);
        hit = 0; i = 0;
        while (!hit && i < 50) begin
            @(negedge clk);
            if (req0_dvalid) hit = 1;
            i++;
        end
        gap_ok = ok && hit && busy && !mm_rden && !mm_we;
        #1;
        inj_valid = 1'b1;
        @(posedge clk); #1;
        inj_valid = 1'b0;
        wait_done(0, dc, ok2);
        compared++;
        if (!gap_ok || !ok2) begin
            mismatched++;
            $display("FAIL gap_inject_setup: got gap=%0d done=%0d want 1 1", gap_ok, ok2);
        end
        compared++;
        if (dv_port.size() - b_dv !== 8 || acc_addr.size() - b_acc !== 8) begin
            mismatched++;
            $display("FAIL gap_inject_counts: got dv=%0d acc=%0d want 8 8",
                     dv_port.size() - b_dv, acc_addr.size() - b_acc);
        end
        for (int k = 0; k < 8 && b_dv + k < dv_widx.size(); k++) begin
            compared++;
            if (dv_widx[b_dv+k] !== k || dv_data[b_dv+k] !== mem_word(14'(128 + k))) begin
                mismatched++;
                $display("FAIL gap_inject_word%0d: got widx=%0d data=%h want %0d %h", k,
                         dv_widx[b_dv+k], dv_data[b_dv+k], k, mem_word(14'(128 + k)));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        inj_valid = 1'b0;
        req0_valid = 1'b0; req0_addr = '0;
        req1_valid = 1'b0; req1_we = 1'b0;
        req1_addr = '0; req1_wdata = '0;
        tick(2);
        test_reset();
        test_port0_fill();
        test_arbitration();
        test_write();
        test_port1_fill();
        test_reset_abort();
        test_spurious_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
